// File: rtl/slib_pkg.sv
// Purpose: shared types and saturating-arithmetic helpers for the slib filter blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package slib_pkg;

  // Per-channel filter state; Q is high exactly when the state is MVF_HIGH.
  typedef enum logic {
    MVF_LOW  = 1'b0,
    MVF_HIGH = 1'b1
  } mvf_state_t;

  // Increment, clamped at 2**width-1. The input is masked to width bits and
  // carried one bit wider than the counter so the clamp sees the carry.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [32:0] cmax;
    logic [32:0] sum;
    cmax = (33'd1 << width) - 33'd1;
    sum  = ({1'b0, cnt} & cmax) + 33'd1;
    if (sum > cmax) begin
      sum = cmax;
    end
    return sum[31:0];
  endfunction

  // Decrement, clamped at zero; never wraps to the top of the range.
  function automatic logic [31:0] sat_dec(input logic [31:0] cnt, input int unsigned width);
    logic [32:0] cmax;
    logic [32:0] val;
    cmax = (33'd1 << width) - 33'd1;
    val  = {1'b0, cnt} & cmax;
    if (val != 33'd0) begin
      val = val - 33'd1;
    end
    return val[31:0];
  endfunction

  // Legal threshold configuration: 0 <= lo < hi <= 2**width-1.
  function automatic bit mvf_cfg_ok(input int width, input int hi, input int lo);
    longint cmax;
    cmax = (longint'(1) << width) - 1;
    return (width >= 1) && (lo >= 0) && (lo < hi) && (longint'(hi) <= cmax);
  endfunction

endpackage

// File: rtl/slib_mv_filter_ch.sv
// Purpose: one integrating filter channel (saturating counter + LOW/HIGH hysteresis FSM).
// Latency: q_o changes on the same edge as the counter update that crosses a threshold.
// Backpressure: none; counter moves only when sample_i is high, clear_i has priority.
// Optional: SLIB_MV_FILTER_EDGE_EN adds registered rise_o/fall_o pulses.
module slib_mv_filter_ch
  import slib_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int HI_THRESH = 10,
  parameter int LO_THRESH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sample_i,
  input  logic             clear_i,
  input  logic             d_i,
  output logic             q_o,
  output logic [WIDTH-1:0] cnt_o
`ifdef SLIB_MV_FILTER_EDGE_EN
  ,
  output logic             rise_o,
  output logic             fall_o
`endif
);

  localparam logic [WIDTH-1:0] HI_T = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0] LO_T = WIDTH'(LO_THRESH);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  mvf_state_t       state_q, state_d;

  // Next count and next state; thresholds are tested against the next count.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (clear_i) begin
      cnt_d   = '0;
      state_d = MVF_LOW;
    end else begin
      if (sample_i) begin
        if (d_i) begin
          cnt_d = WIDTH'(sat_inc(32'(cnt_q), WIDTH));
        end else begin
          cnt_d = WIDTH'(sat_dec(32'(cnt_q), WIDTH));
        end
      end
      if ((state_q == MVF_LOW) && (cnt_d >= HI_T)) begin
        state_d = MVF_HIGH;
      end else if ((state_q == MVF_HIGH) && (cnt_d <= LO_T)) begin
        state_d = MVF_LOW;
      end
    end
  end

  // Counter and state flops; reset discards all history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      state_q <= MVF_LOW;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign q_o   = (state_q == MVF_HIGH);
  assign cnt_o = cnt_q;

`ifdef SLIB_MV_FILTER_EDGE_EN
  logic q_dly_q;
  logic rise_q;
  logic fall_q;

  // Edge pulses one cycle after Q moves; reset zeroes the delay copy too, so no pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_dly_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      q_dly_q <= q_o;
      rise_q  <= q_o & ~q_dly_q;
      fall_q  <= ~q_o & q_dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/slib_mv_filter_mc.sv
// Purpose: CHANNELS independent integrating input filters sharing one SAMPLE strobe.
// Latency: Q[i] updates on the edge whose sample crosses a threshold; CNT0 is channel 0's counter.
// Backpressure: none; per-channel CLEAR overrides SAMPLE/D.
// Optional: SLIB_MV_FILTER_EDGE_EN adds RISE/FALL pulse outputs.
module slib_mv_filter_mc
  import slib_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 4,
  parameter int HI_THRESH = 10,
  parameter int LO_THRESH = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SAMPLE,
  input  logic [CHANNELS-1:0] CLEAR,
  input  logic [CHANNELS-1:0] D,
  output logic [CHANNELS-1:0] Q,
  output logic [WIDTH-1:0]    CNT0
`ifdef SLIB_MV_FILTER_EDGE_EN
  ,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL
`endif
);

  // Reject impossible configurations at elaboration.
  if (CHANNELS < 1 || !mvf_cfg_ok(WIDTH, HI_THRESH, LO_THRESH)) begin : g_bad_cfg
    $fatal(1, "slib_mv_filter_mc: need CHANNELS>=1 and 0 <= LO_THRESH < HI_THRESH <= 2**WIDTH-1");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_w;

    slib_mv_filter_ch #(
      .WIDTH     (WIDTH),
      .HI_THRESH (HI_THRESH),
      .LO_THRESH (LO_THRESH)
    ) u_ch (
      .CLK      (CLK),
      .RST      (RST),
      .sample_i (SAMPLE),
      .clear_i  (CLEAR[g]),
      .d_i      (D[g]),
      .q_o      (Q[g]),
      .cnt_o    (cnt_w)
`ifdef SLIB_MV_FILTER_EDGE_EN
      ,
      .rise_o   (RISE[g]),
      .fall_o   (FALL[g])
`endif
    );

    // Only channel 0's count is brought out for debug.
    if (g == 0) begin : g_tap
      assign CNT0 = cnt_w;
    end else begin : g_notap
      logic unused_cnt;
      assign unused_cnt = ^cnt_w;
    end
  end

endmodule

// File: tb/tb_slib_mv_filter_mc.sv
module tb_slib_mv_filter_mc;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SAMPLE;
  logic [3:0] CLEAR;
  logic [3:0] D;
  logic [3:0] Q;
  logic [3:0] CNT0;
`ifdef SLIB_MV_FILTER_EDGE_EN
  logic [3:0] RISE;
  logic [3:0] FALL;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int m_cnt[4];
  bit m_q[4];

  always #5 CLK = ~CLK;

  slib_mv_filter_mc #(
    .CHANNELS  (4),
    .WIDTH     (4),
    .HI_THRESH (10),
    .LO_THRESH (5)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SAMPLE (SAMPLE),
    .CLEAR  (CLEAR),
    .D      (D),
    .Q      (Q),
    .CNT0   (CNT0)
`ifdef SLIB_MV_FILTER_EDGE_EN
    ,
    .RISE   (RISE),
    .FALL   (FALL)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: CMAX=15, HI=10, LO=5.
  task automatic model_step(input logic [3:0] d, input logic [3:0] clr);
    for (int c = 0; c < 4; c++) begin
      if (clr[c]) begin
        m_cnt[c] = 0;
        m_q[c]   = 1'b0;
      end else begin
        if (d[c]) m_cnt[c] = (m_cnt[c] < 15) ? m_cnt[c] + 1 : 15;
        else      m_cnt[c] = (m_cnt[c] > 0) ? m_cnt[c] - 1 : 0;
        if (!m_q[c] && m_cnt[c] >= 10)     m_q[c] = 1'b1;
        else if (m_q[c] && m_cnt[c] <= 5)  m_q[c] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0;
      m_q[c]   = 1'b0;
    end
  endtask

  function automatic logic [3:0] model_qv();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_q[c];
    return v;
  endfunction

  // One SAMPLE pulse followed by two idle cycles (3-cycle spacing).
  task automatic do_sample(input logic [3:0] d, input string tag);
    logic [3:0] q_before;
    q_before = model_qv();
    D      = d;
    SAMPLE = 1'b1;
    @(posedge CLK); #1;
    SAMPLE = 1'b0;
    model_step(d, 4'b0000);
    chk({tag, " Q"}, 32'(Q), 32'(model_qv()));
    chk({tag, " CNT0"}, 32'(CNT0), 32'(m_cnt[0]));
    @(posedge CLK); #1;
`ifdef SLIB_MV_FILTER_EDGE_EN
    chk({tag, " RISE"}, 32'(RISE), 32'(model_qv() & ~q_before));
    chk({tag, " FALL"}, 32'(FALL), 32'(~model_qv() & q_before));
`endif
    @(posedge CLK); #1;
`ifdef SLIB_MV_FILTER_EDGE_EN
    chk({tag, " RISE idle"}, 32'(RISE), 32'h0);
    chk({tag, " FALL idle"}, 32'(FALL), 32'h0);
`endif
  endtask

  initial begin
    RST = 1'b1; SAMPLE = 1'b0; CLEAR = 4'b0; D = 4'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset Q", 32'(Q), 32'h0);
    chk("reset CNT0", 32'(CNT0), 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Ramp channel 0 up to the high threshold.
    for (int i = 1; i <= 10; i++) begin
      do_sample(4'b0001, "ramp");
      chk("ramp cnt0", 32'(CNT0), 32'(i));
      chk("ramp q0", 32'(Q[0]), 32'(i >= 10));
      chk("ramp q31", 32'(Q[3:1]), 32'h0);
    end
    // D wiggling without SAMPLE moves nothing.
    for (int i = 0; i < 4; i++) begin
      D = (i % 2 == 0) ? 4'hF : 4'h0;
      @(posedge CLK); #1;
      chk("nosample cnt0", 32'(CNT0), 32'd10);
      chk("nosample Q", 32'(Q), 32'h1);
    end

    // Saturate at 15, then fall through LO at 5, then floor at 0.
    for (int i = 1; i <= 8; i++) begin
      do_sample(4'b0001, "sat");
      chk("sat cnt0", 32'(CNT0), 32'((10 + i > 15) ? 15 : 10 + i));
      chk("sat q0", 32'(Q[0]), 32'h1);
    end
    for (int i = 1; i <= 10; i++) begin
      do_sample(4'b0000, "down");
      chk("down cnt0", 32'(CNT0), 32'(15 - i));
      chk("down q0", 32'(Q[0]), 32'(i < 10));
    end
    for (int i = 1; i <= 7; i++) begin
      do_sample(4'b0000, "floor");
      chk("floor cnt0", 32'(CNT0), 32'((i < 5) ? 5 - i : 0));
      chk("floor q0", 32'(Q[0]), 32'h0);
    end

    // Hysteresis while HIGH: park at 7, oscillate 6/7.
    for (int i = 0; i < 10; i++) do_sample(4'b0001, "hyst up");
    for (int i = 0; i < 3; i++)  do_sample(4'b0000, "hyst dn");
    chk("hyst start cnt0", 32'(CNT0), 32'd7);
    chk("hyst start q0", 32'(Q[0]), 32'h1);
    for (int i = 0; i < 20; i++) begin
      do_sample((i % 2 == 0) ? 4'b0000 : 4'b0001, "hyst hi");
      chk("hyst hi cnt0", 32'(CNT0), 32'((i % 2 == 0) ? 6 : 7));
      chk("hyst hi q0", 32'(Q[0]), 32'h1);
    end
    // Hysteresis while LOW: fall at 5, climb to 8, oscillate 9/8.
    do_sample(4'b0000, "hyst fall");
    do_sample(4'b0000, "hyst fall");
    chk("hyst fall cnt0", 32'(CNT0), 32'd5);
    chk("hyst fall q0", 32'(Q[0]), 32'h0);
    for (int i = 0; i < 3; i++) do_sample(4'b0001, "hyst climb");
    chk("hyst lo start cnt0", 32'(CNT0), 32'd8);
    for (int i = 0; i < 20; i++) begin
      do_sample((i % 2 == 0) ? 4'b0001 : 4'b0000, "hyst lo");
      chk("hyst lo cnt0", 32'(CNT0), 32'((i % 2 == 0) ? 9 : 8));
      chk("hyst lo q0", 32'(Q[0]), 32'h0);
    end

    // Channel 1 to 12, then CLEAR wins over SAMPLE with D=1.
    for (int i = 0; i < 12; i++) do_sample(4'b0010, "ch1 up");
    chk("ch1 high", 32'(Q[1]), 32'h1);
    D = 4'b0010; SAMPLE = 1'b1; CLEAR = 4'b0010;
    @(posedge CLK); #1;
    SAMPLE = 1'b0; CLEAR = 4'b0000;
    model_step(4'b0010, 4'b0010);
    chk("clear q1", 32'(Q[1]), 32'h0);
    chk("clear Q", 32'(Q), 32'(model_qv()));
    chk("clear cnt0", 32'(CNT0), 32'(m_cnt[0]));
`ifdef SLIB_MV_FILTER_EDGE_EN
    chk("clear FALL early", 32'(FALL), 32'h0);
    @(posedge CLK); #1;
    chk("clear FALL pulse", 32'(FALL), 32'b0010);
    chk("clear RISE", 32'(RISE), 32'h0);
    @(posedge CLK); #1;
    chk("clear FALL end", 32'(FALL), 32'h0);
`endif
    for (int i = 1; i <= 10; i++) begin
      do_sample(4'b0010, "ch1 reclimb");
      chk("ch1 reclimb q1", 32'(Q[1]), 32'(i >= 10));
    end

    // Asynchronous reset mid-run with nonzero counters.
    for (int i = 0; i < 3; i++) do_sample(4'b0011, "pre rst");
    chk("pre rst cnt0", 32'(CNT0), 32'd3);
    RST = 1'b1;
    #1;
    chk("async rst Q", 32'(Q), 32'h0);
    chk("async rst CNT0", 32'(CNT0), 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("held rst Q", 32'(Q), 32'h0);
    RST = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    chk("post rst Q", 32'(Q), 32'h0);
    chk("post rst CNT0", 32'(CNT0), 32'h0);
`ifdef SLIB_MV_FILTER_EDGE_EN
    chk("post rst RISE", 32'(RISE), 32'h0);
    chk("post rst FALL", 32'(FALL), 32'h0);
`endif
    do_sample(4'b0001, "post rst");
    chk("post rst first cnt0", 32'(CNT0), 32'd1);

    // All channels at once with distinct patterns.
    for (int i = 0; i < 12; i++) begin
      logic [3:0] d;
      d[0] = (i % 3 != 2);
      d[1] = (i % 4 != 3);
      d[2] = 1'b1;
      d[3] = 1'b0;
      do_sample(d, "multi");
      chk("multi q2", 32'(Q[2]), 32'(i >= 9));
      chk("multi q3", 32'(Q[3]), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
